// File: rtl/wb_stage.sv
// wb_stage: registered MIPS write-back stage that shares the register-file port with an MDU pending-write queue.
// Optional build macro WB_LOAD_EXT_EN enables byte/halfword load extension on the memory path.
module wb_stage #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int QDEPTH = 2,
   localparam int CW = $clog2(QDEPTH) + 1,
   localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              w_valid,
   input  logic              w_regwrite,
   input  logic [1:0]        w_sel,
   input  logic [2:0]        w_ext_op,
   input  logic [DATA_W-1:0] w_alu,
   input  logic [DATA_W-1:0] w_mem,
   input  logic [DATA_W-1:0] w_pc4,
   input  logic [REG_AW-1:0] w_dst,
   input  logic              md_valid,
   input  logic [REG_AW-1:0] md_dst,
   input  logic [DATA_W-1:0] md_data,
   output logic              md_ready,
   input  logic [REG_AW-1:0] q_addr,
   output logic              pend_hit,
   output logic              stall_w,
   output logic [CW-1:0]     q_count,
   output logic              rf_we,
   output logic [REG_AW-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_wdata
);

   logic [REG_AW-1:0] r_q_dst  [QDEPTH];
   logic [DATA_W-1:0] r_q_data [QDEPTH];
   logic [QDEPTH-1:0] r_q_vld;
   logic [PW-1:0]     r_rd_ptr;
   logic [PW-1:0]     r_wr_ptr;
   logic [CW-1:0]     r_count;

   logic              w_full;
   logic              w_empty;
   logic              w_pipe_req;
   logic              w_enq;
   logic              w_deq;
   logic              w_hit;
   logic [DATA_W-1:0] w_load_data;
   logic [DATA_W-1:0] w_pipe_data;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Flow control looks only at the registered count, so full/ready never depend on this cycle's traffic.
   assign w_full     = (r_count == CW'(QDEPTH));
   assign w_empty    = (r_count == '0);
   assign stall_w    = !reset && w_full;
   assign md_ready   = !reset && (r_count < CW'(QDEPTH));
   assign q_count    = r_count;
   assign w_pipe_req = w_valid && w_regwrite && (w_sel != 2'b11) && (w_dst != '0) && !stall_w;
   assign w_enq      = md_valid && md_ready && (md_dst != '0);
   assign w_deq      = !w_empty && (w_full || !w_pipe_req);

   always_comb begin
      w_hit = 1'b0;
      for (int i = 0; i < QDEPTH; i++) begin
         if (r_q_vld[i] && (r_q_dst[i] == q_addr)) w_hit = 1'b1;
      end
   end
   assign pend_hit = !reset && (q_addr != '0) && w_hit;

`ifdef WB_LOAD_EXT_EN
   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Lanes are taken from the low 32-bit word; bit 0 of the address is ignored for halfwords.
   always_comb begin
      w_half = w_alu[1] ? w_mem[31:16] : w_mem[15:0];
      case (w_alu[1:0])
         2'd0:    w_byte = w_mem[7:0];
         2'd1:    w_byte = w_mem[15:8];
         2'd2:    w_byte = w_mem[23:16];
         default: w_byte = w_mem[31:24];
      endcase
      case (w_ext_op)
         3'b001:  w_load_data = {{(DATA_W-8){1'b0}}, w_byte};
         3'b010:  w_load_data = {{(DATA_W-8){w_byte[7]}}, w_byte};
         3'b011:  w_load_data = {{(DATA_W-16){1'b0}}, w_half};
         3'b100:  w_load_data = {{(DATA_W-16){w_half[15]}}, w_half};
         default: w_load_data = w_mem;
      endcase
   end
`else
   logic w_unused_ext;
   assign w_unused_ext = ^w_ext_op;
   assign w_load_data  = w_mem;
`endif

   always_comb begin
      case (w_sel)
         2'b01:   w_pipe_data = w_load_data;
         2'b10:   w_pipe_data = w_pc4 + DATA_W'(4);
         default: w_pipe_data = w_alu;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
         r_q_vld  <= '0;
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
      end else begin
         if (w_enq) begin
            r_q_dst[r_wr_ptr]  <= md_dst;
            r_q_data[r_wr_ptr] <= md_data;
            r_q_vld[r_wr_ptr]  <= 1'b1;
            r_wr_ptr           <= ptr_inc(r_wr_ptr);
         end
         // Enqueue and dequeue never hit the same slot: that needs an empty or a full queue.
         if (w_deq) begin
            r_q_vld[r_rd_ptr] <= 1'b0;
            r_rd_ptr          <= ptr_inc(r_rd_ptr);
         end
         r_count <= r_count + CW'(w_enq) - CW'(w_deq);

         if (w_pipe_req) begin
            rf_we    <= 1'b1;
            rf_waddr <= w_dst;
            rf_wdata <= w_pipe_data;
         end else if (w_deq) begin
            rf_we    <= 1'b1;
            rf_waddr <= r_q_dst[r_rd_ptr];
            rf_wdata <= r_q_data[r_rd_ptr];
         end else begin
            rf_we <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: pipeline write paths, MDU queue arbitration, full/stall and reset drop.
module tb_wb_stage;

   logic        clk;
   logic        reset;
   logic        w_valid;
   logic        w_regwrite;
   logic [1:0]  w_sel;
   logic [2:0]  w_ext_op;
   logic [31:0] w_alu;
   logic [31:0] w_mem;
   logic [31:0] w_pc4;
   logic [4:0]  w_dst;
   logic        md_valid;
   logic [4:0]  md_dst;
   logic [31:0] md_data;
   logic        md_ready;
   logic [4:0]  q_addr;
   logic        pend_hit;
   logic        stall_w;
   logic [1:0]  q_count;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;

   int checks = 0;
   int errors = 0;
   logic [36:0] exp_q[$];

   wb_stage #(.DATA_W(32), .REG_AW(5), .QDEPTH(2)) dut (
      .clk(clk), .reset(reset),
      .w_valid(w_valid), .w_regwrite(w_regwrite), .w_sel(w_sel), .w_ext_op(w_ext_op),
      .w_alu(w_alu), .w_mem(w_mem), .w_pc4(w_pc4), .w_dst(w_dst),
      .md_valid(md_valid), .md_dst(md_dst), .md_data(md_data), .md_ready(md_ready),
      .q_addr(q_addr), .pend_hit(pend_hit), .stall_w(stall_w), .q_count(q_count),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // scoreboard: every register-file write must match the oldest expected write
   always @(negedge clk) begin
      if (rf_we) begin
         logic [36:0] e;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got write r%0d=%h, expected none", rf_waddr, rf_wdata);
         end else begin
            e = exp_q.pop_front();
            if ({rf_waddr, rf_wdata} !== e) begin
               errors++;
               $display("FAIL sb_write: got r%0d=%h, expected r%0d=%h", rf_waddr, rf_wdata, e[36:32], e[31:0]);
            end
         end
      end
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      w_valid = 0; w_regwrite = 0; w_sel = 0; w_ext_op = 0;
      w_alu = 0; w_mem = 0; w_pc4 = 0; w_dst = 0;
   endtask

   task automatic drive_w(input logic [1:0] sel, input logic [2:0] ext, input logic [31:0] alu,
                          input logic [31:0] mem, input logic [31:0] pc4, input logic [4:0] dst);
      w_valid = 1; w_regwrite = 1; w_sel = sel; w_ext_op = ext;
      w_alu = alu; w_mem = mem; w_pc4 = pc4; w_dst = dst;
   endtask

   task automatic offer_md(input logic [4:0] dst, input logic [31:0] data);
      md_valid = 1; md_dst = dst; md_data = data;
   endtask

   task automatic test_reset();
      reset = 1; set_idle(); md_valid = 0; md_dst = 0; md_data = 0; q_addr = 5;
      tick(); tick();
      checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b, expected 0", rf_we); end
      checks++; if (rf_waddr !== 5'd0) begin errors++; $display("FAIL reset_waddr: got %0d, expected 0", rf_waddr); end
      checks++; if (rf_wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata: got %h, expected 0", rf_wdata); end
      checks++; if (q_count !== 2'd0) begin errors++; $display("FAIL reset_qcount: got %0d, expected 0", q_count); end
      checks++; if (stall_w !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b, expected 0", stall_w); end
      checks++; if (md_ready !== 1'b0) begin errors++; $display("FAIL reset_mdready: got %b, expected 0", md_ready); end
      checks++; if (pend_hit !== 1'b0) begin errors++; $display("FAIL reset_pendhit: got %b, expected 0", pend_hit); end
      reset = 0;
      #1;
      checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL post_reset_mdready: got %b, expected 1", md_ready); end
      tick();
   endtask

   task automatic test_alu();
      drive_w(2'b00, 3'b000, 32'h12345678, 32'h0, 32'h0, 5'd8);
      exp_q.push_back({5'd8, 32'h12345678});
      tick();
      checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL alu_we: got %b, expected 1", rf_we); end
      checks++; if (rf_waddr !== 5'd8) begin errors++; $display("FAIL alu_waddr: got %0d, expected 8", rf_waddr); end
      checks++; if (rf_wdata !== 32'h12345678) begin errors++; $display("FAIL alu_wdata: got %h, expected 12345678", rf_wdata); end
      set_idle();
      tick();
      checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL idle_we: got %b, expected 0", rf_we); end
   endtask

   task automatic test_load();
      logic [2:0]  ops [7] = '{3'b010, 3'b001, 3'b100, 3'b011, 3'b000, 3'b111, 3'b010};
      logic [31:0] alus[7] = '{32'h2, 32'h3, 32'h2, 32'h1, 32'h1, 32'h0, 32'h1};
      logic [31:0] mems[7] = '{32'h00800000, 32'hAB000000, 32'h80010000, 32'h1234F00D,
                               32'hCAFEBABE, 32'h87654321, 32'h00007F00};
      logic [31:0] exts[7] = '{32'hFFFFFF80, 32'h000000AB, 32'hFFFF8001, 32'h0000F00D,
                               32'hCAFEBABE, 32'h87654321, 32'h0000007F};
      for (int i = 0; i < 7; i++) begin
         logic [31:0] e;
`ifdef WB_LOAD_EXT_EN
         e = exts[i];
`else
         e = mems[i];
`endif
         drive_w(2'b01, ops[i], alus[i], mems[i], 32'h0, 5'(3 + i));
         exp_q.push_back({5'(3 + i), e});
         tick();
         checks++;
         if (rf_wdata !== e) begin errors++; $display("FAIL load_%0d: got %h, expected %h", i, rf_wdata, e); end
      end
      set_idle();
      tick();
   endtask

   task automatic test_link();
      drive_w(2'b10, 3'b000, 32'h0, 32'h0, 32'h00003004, 5'd31);
      exp_q.push_back({5'd31, 32'h00003008});
      tick();
      checks++; if (rf_wdata !== 32'h00003008) begin errors++; $display("FAIL link_wdata: got %h, expected 00003008", rf_wdata); end
      w_dst = 5'd0;
      tick();
      checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL link_r0_we: got %b, expected 0", rf_we); end
      drive_w(2'b10, 3'b000, 32'h0, 32'h0, 32'hFFFFFFFC, 5'd2);
      exp_q.push_back({5'd2, 32'h0});
      tick();
      checks++; if (rf_wdata !== 32'h0) begin errors++; $display("FAIL link_wrap: got %h, expected 00000000", rf_wdata); end
      drive_w(2'b11, 3'b000, 32'h55, 32'h0, 32'h0, 5'd4);
      tick();
      checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL sel11_we: got %b, expected 0", rf_we); end
      set_idle();
      tick();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 40; i++) begin
         logic        v, rw, ew;
         logic [1:0]  sel;
         logic [4:0]  dst;
         logic [31:0] alu, mem, pc4, e;
         v = 1'($urandom_range(0, 3) != 0); rw = 1'($urandom_range(0, 3) != 0);
         sel = 2'($urandom_range(0, 3)); dst = 5'($urandom_range(0, 31));
         alu = $urandom; mem = $urandom; pc4 = $urandom;
         drive_w(sel, 3'b000, alu, mem, pc4, dst);
         w_valid = v; w_regwrite = rw;
         e = (sel == 2'b00) ? alu : (sel == 2'b01) ? mem : pc4 + 32'd4;
         ew = v && rw && (sel != 2'b11) && (dst != 5'd0);
         if (ew) exp_q.push_back({dst, e});
         tick();
         checks++;
         if (rf_we !== ew) begin errors++; $display("FAIL b2b_we_%0d: got %b, expected %b", i, rf_we, ew); end
      end
      set_idle();
      tick();
   endtask

   task automatic test_arbitration();
      offer_md(5'd0, 32'h55);
      #1;
      checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL md0_ready: got %b, expected 1", md_ready); end
      tick();
      md_valid = 0;
      checks++; if (q_count !== 2'd0) begin errors++; $display("FAIL md0_qcount: got %0d, expected 0", q_count); end
      for (int c = 0; c < 3; c++) begin
         drive_w(2'b00, 3'b000, 32'h1000 + c, 32'h0, 32'h0, 5'(20 + c));
         exp_q.push_back({5'(20 + c), 32'h1000 + c});
         if (c == 0) offer_md(5'd9, 32'hAA);
         tick();
         md_valid = 0;
      end
      q_addr = 5'd9; #1;
      checks++; if (q_count !== 2'd1) begin errors++; $display("FAIL arb_qcount: got %0d, expected 1", q_count); end
      checks++; if (pend_hit !== 1'b1) begin errors++; $display("FAIL arb_pend9: got %b, expected 1", pend_hit); end
      q_addr = 5'd8; #1;
      checks++; if (pend_hit !== 1'b0) begin errors++; $display("FAIL arb_pend8: got %b, expected 0", pend_hit); end
      q_addr = 5'd9;
      set_idle();
      exp_q.push_back({5'd9, 32'hAA});
      tick();
      checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'hAA) begin
         errors++; $display("FAIL arb_drain: got we=%b r%0d=%h, expected we=1 r9=000000aa", rf_we, rf_waddr, rf_wdata);
      end
      checks++; if (q_count !== 2'd0) begin errors++; $display("FAIL arb_qcount0: got %0d, expected 0", q_count); end
      checks++; if (pend_hit !== 1'b0) begin errors++; $display("FAIL arb_pend_clear: got %b, expected 0", pend_hit); end
      tick();
   endtask

   task automatic test_full_stall();
      q_addr = 5'd11;
      drive_w(2'b00, 3'b000, 32'h2001, 32'h0, 32'h0, 5'd21);
      offer_md(5'd10, 32'h100);
      exp_q.push_back({5'd21, 32'h2001});
      tick();
      checks++; if (q_count !== 2'd1 || stall_w !== 1'b0) begin
         errors++; $display("FAIL full_step1: got count=%0d stall=%b, expected count=1 stall=0", q_count, stall_w);
      end
      drive_w(2'b00, 3'b000, 32'h2002, 32'h0, 32'h0, 5'd22);
      offer_md(5'd11, 32'h200);
      exp_q.push_back({5'd22, 32'h2002});
      tick();
      checks++; if (q_count !== 2'd2) begin errors++; $display("FAIL full_qcount: got %0d, expected 2", q_count); end
      checks++; if (stall_w !== 1'b1) begin errors++; $display("FAIL full_stall: got %b, expected 1", stall_w); end
      checks++; if (md_ready !== 1'b0) begin errors++; $display("FAIL full_mdready: got %b, expected 0", md_ready); end
      checks++; if (pend_hit !== 1'b1) begin errors++; $display("FAIL full_pend11: got %b, expected 1", pend_hit); end
      drive_w(2'b00, 3'b000, 32'hDEAD, 32'h0, 32'h0, 5'd12);
      offer_md(5'd13, 32'h300);
      exp_q.push_back({5'd10, 32'h100});
      tick();
      md_valid = 0;
      checks++; if (rf_waddr !== 5'd10 || rf_wdata !== 32'h100) begin
         errors++; $display("FAIL full_drain1: got r%0d=%h, expected r10=00000100", rf_waddr, rf_wdata);
      end
      checks++; if (q_count !== 2'd1 || stall_w !== 1'b0) begin
         errors++; $display("FAIL full_after1: got count=%0d stall=%b, expected count=1 stall=0", q_count, stall_w);
      end
      set_idle();
      exp_q.push_back({5'd11, 32'h200});
      tick();
      checks++; if (rf_waddr !== 5'd11 || rf_wdata !== 32'h200) begin
         errors++; $display("FAIL full_drain2: got r%0d=%h, expected r11=00000200", rf_waddr, rf_wdata);
      end
      checks++; if (q_count !== 2'd0 || stall_w !== 1'b0 || pend_hit !== 1'b0) begin
         errors++; $display("FAIL full_empty: got count=%0d stall=%b hit=%b, expected 0 0 0", q_count, stall_w, pend_hit);
      end
      tick();
   endtask

   task automatic test_reset_drain();
      q_addr = 5'd14;
      drive_w(2'b00, 3'b000, 32'h3001, 32'h0, 32'h0, 5'd23);
      offer_md(5'd14, 32'h400);
      exp_q.push_back({5'd23, 32'h3001});
      tick();
      drive_w(2'b00, 3'b000, 32'h3002, 32'h0, 32'h0, 5'd24);
      offer_md(5'd15, 32'h500);
      exp_q.push_back({5'd24, 32'h3002});
      tick();
      md_valid = 0;
      checks++; if (q_count !== 2'd2) begin errors++; $display("FAIL rd_fill: got %0d, expected 2", q_count); end
      set_idle();
      reset = 1;
      #1;
      checks++; if (md_ready !== 1'b0 || stall_w !== 1'b0 || pend_hit !== 1'b0) begin
         errors++; $display("FAIL rd_in_reset: got ready=%b stall=%b hit=%b, expected 0 0 0", md_ready, stall_w, pend_hit);
      end
      tick();
      checks++; if (rf_we !== 1'b0 || q_count !== 2'd0) begin
         errors++; $display("FAIL rd_reset_edge: got we=%b count=%0d, expected 0 0", rf_we, q_count);
      end
      reset = 0;
      repeat (4) tick();
      checks++; if (rf_we !== 1'b0 || q_count !== 2'd0) begin
         errors++; $display("FAIL rd_after: got we=%b count=%0d, expected 0 0", rf_we, q_count);
      end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_load();
      test_link();
      test_back_to_back();
      test_arbitration();
      test_full_stall();
      test_reset_drain();
      tick();
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL sb_leftover: got %0d pending expected writes, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
